// File: rtl/running_light_pkg.sv
// Shared types and constants for the running-light sequencer.
// Holds the control FSM encoding and the speed range.
package running_light_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(7);

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, press pulse.
// A press is a one-cycle debounced rising edge; releases are silent.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Only a flip towards 1 is reported.
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/running_light_ctrl.sv
// Running-light sequencer: debounced buttons drive speed/pause control
// and a programmable prescaler that paces the shift register.
module running_light_ctrl
    import running_light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BASE_DIV        = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_dir,
    input  logic               btn_faster,
    input  logic               btn_slower,
    input  logic               btn_pause,
    output logic               step_en,
    output logic               toggle_dir,
    output logic               sr_reset,
    output logic [SPEED_W-1:0] speed,
    output logic               paused
);

    localparam int PW = $clog2(BASE_DIV);

    logic dir_press;
    logic faster_press;
    logic slower_press;
    logic pause_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_dir),
        .press (dir_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_faster),
        .press (faster_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_slower),
        .press (slower_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_pause),
        .press (pause_press)
    );

    state_t             state;
    state_t             state_next;
    logic [SPEED_W-1:0] speed_q;
    logic [PW-1:0]      cnt;
    logic [PW-1:0]      cnt_last;
    logic [PW:0]        period;
    logic               active;
    logic               speed_up;
    logic               speed_down;
    logic               speed_chg;
    logic               at_last;
    logic               sr_pulse;
    logic               step_pulse;
    logic               toggle_pulse;

    assign active     = (state != ST_INIT);
    assign speed_up   = active && faster_press && !slower_press
                        && (speed_q != SPEED_MAX);
    assign speed_down = active && slower_press && !faster_press
                        && (speed_q != '0);
    assign speed_chg  = speed_up || speed_down;

    // period can equal 2**PW at speed 0, so it carries one extra bit.
    assign period   = (PW+1)'(BASE_DIV >> speed_q);
    assign cnt_last = PW'(period - 1'b1);
    assign at_last  = (cnt == cnt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        sr_pulse     = 1'b0;
        step_pulse   = 1'b0;
        toggle_pulse = 1'b0;
        unique case (state)
            ST_INIT: begin
                sr_pulse   = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                step_pulse   = at_last && !speed_chg;
                toggle_pulse = dir_press;
                if (pause_press) state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                toggle_pulse = dir_press;
                if (pause_press) state_next = ST_RUN;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q <= '0;
            cnt     <= '0;
        end else begin
            if (speed_up) begin
                speed_q <= speed_q + 1'b1;
            end else if (speed_down) begin
                speed_q <= speed_q - 1'b1;
            end
            // A speed change restarts the period and drops any due step.
            if (speed_chg || state == ST_INIT) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                cnt <= at_last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign step_en    = step_pulse && !reset;
    assign toggle_dir = toggle_pulse && !reset;
    assign sr_reset   = sr_pulse && !reset;
    assign speed      = reset ? '0 : speed_q;
    assign paused     = (state == ST_PAUSE) && !reset;

endmodule

// File: tb/tb_running_light_ctrl.sv
// Bench for running_light_ctrl: directed and random button activity
// checked every cycle against a rule-level reference model.
module tb_running_light_ctrl;

    localparam int N    = 4;
    localparam int BASE = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_dir = 1'b0;
    logic       btn_faster = 1'b0;
    logic       btn_slower = 1'b0;
    logic       btn_pause = 1'b0;
    logic       step_en;
    logic       toggle_dir;
    logic       sr_reset;
    logic [2:0] speed;
    logic       paused;

    running_light_ctrl #(
        .DEBOUNCE_CYCLES (N),
        .BASE_DIV        (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_dir    (btn_dir),
        .btn_faster (btn_faster),
        .btn_slower (btn_slower),
        .btn_pause  (btn_pause),
        .step_en    (step_en),
        .toggle_dir (toggle_dir),
        .sr_reset   (sr_reset),
        .speed      (speed),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Inputs for the next cycle; index 0 dir, 1 faster, 2 slower, 3 pause.
    bit       p_reset = 1'b1;
    bit [3:0] p_btn = 4'b0;

    // Reference model state, valid for the upcoming cycle.
    bit [15:0] hist [4];
    bit        m_lvl [4];
    bit        m_press [4];
    bit        m_init = 1'b1;
    bit        m_paused = 1'b0;
    int        m_speed = 0;
    int        m_phase = 0;

    // Observation log.
    int step_cnt = 0, tog_cnt = 0, both_cnt = 0;
    int last_step = -1, prev_step = -1, first_step = -1;
    int last_tog = -1, sr_cyc = -1, pause_cyc = -1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        int per;
        bit f, s, chg;
        logic [6:0] e_vec, o_vec;
        bit [N-1:0] win;
        @(posedge clk);
        #1;
        cyc++;
        reset      = p_reset;
        btn_dir    = p_btn[0];
        btn_faster = p_btn[1];
        btn_slower = p_btn[2];
        btn_pause  = p_btn[3];
        #1;
        per = BASE >> m_speed;
        f = m_press[1];
        s = m_press[2];
        chg = !m_init && ((f && !s && m_speed < 7) || (s && !f && m_speed > 0));
        if (p_reset) begin
            e_vec = '0;
        end else begin
            e_vec[6] = !m_init && !m_paused && (m_phase == per - 1) && !chg;
            e_vec[5] = m_press[0] && !m_init;
            e_vec[4] = m_init;
            e_vec[3:1] = 3'(m_speed);
            e_vec[0] = m_paused;
        end
        o_vec = {step_en, toggle_dir, sr_reset, speed, paused};
        checks++;
        assert (o_vec === e_vec) else begin
            errors++;
            $error("FAIL cycle %0d outputs got %b exp %b", cyc, o_vec, e_vec);
        end
        if (step_en === 1'b1) begin
            step_cnt++;
            prev_step = last_step;
            last_step = cyc;
            if (first_step < 0) first_step = cyc;
        end
        if (toggle_dir === 1'b1) begin
            tog_cnt++;
            last_tog = cyc;
        end
        if (step_en === 1'b1 && toggle_dir === 1'b1) both_cnt++;
        if (sr_reset === 1'b1) sr_cyc = cyc;
        if (!p_reset && !m_init && m_press[3]) pause_cyc = cyc;
        // Advance control model using this cycle's presses.
        if (p_reset) begin
            m_init = 1'b1;
            m_paused = 1'b0;
            m_speed = 0;
            m_phase = 0;
        end else begin
            if (chg || m_init) m_phase = 0;
            else if (!m_paused) m_phase = (m_phase + 1) % per;
            if (!m_init && m_press[3]) m_paused = !m_paused;
            if (chg) m_speed = f ? m_speed + 1 : m_speed - 1;
            m_init = 1'b0;
        end
        // A level flips once the last N synchronised samples all disagree.
        for (int b = 0; b < 4; b++) begin
            hist[b] = p_reset ? 16'h0 : {hist[b][14:0], p_btn[b]};
            win = hist[b][N+1:2];
            if (p_reset) begin
                m_lvl[b] = 1'b0;
                m_press[b] = 1'b0;
            end else if (win == {N{~m_lvl[b]}}) begin
                m_lvl[b] = ~m_lvl[b];
                m_press[b] = m_lvl[b];
            end else begin
                m_press[b] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int b, input int hold, input bit glitch);
        if (glitch) begin
            repeat (2) begin
                p_btn[b] = 1'b1;
                idle(2);
                p_btn[b] = 1'b0;
                idle(2);
            end
        end
        p_btn[b] = 1'b1;
        idle(hold);
        p_btn[b] = 1'b0;
        idle(N + 4);
    endtask

    task automatic do_reset(input int n);
        p_btn = 4'b0;
        p_reset = 1'b1;
        idle(n);
        p_reset = 1'b0;
        first_step = -1;
    endtask

    initial begin
        int n, t, k, per;
        for (int b = 0; b < 4; b++) begin
            hist[b] = '0;
            m_lvl[b] = 1'b0;
            m_press[b] = 1'b0;
        end

        // Reset release and the base step period.
        do_reset(5);
        idle(600);
        chk("first_step_gap", first_step - sr_cyc, 256);
        chk("step_spacing_s0", last_step - prev_step, 256);
        chk("speed_after_reset", speed, 0);

        // Three faster presses.
        for (int i = 0; i < 3; i++) press(1, N + 2, i[0]);
        idle(100);
        chk("speed_3", speed, 3);
        chk("step_spacing_s3", last_step - prev_step, 32);

        // Faster and slower together: no change.
        p_btn[1] = 1'b1;
        p_btn[2] = 1'b1;
        idle(N + 2);
        p_btn = 4'b0;
        idle(100);
        chk("speed_both", speed, 3);
        chk("step_spacing_both", last_step - prev_step, 32);

        // Saturate at the top.
        for (int i = 0; i < 10; i++) press(1, N + 1, 1'b0);
        idle(20);
        chk("speed_7", speed, 7);
        chk("step_spacing_s7", last_step - prev_step, 2);

        // Saturate at the bottom.
        for (int i = 0; i < 9; i++) press(2, N + 3, 1'b0);
        idle(20);
        chk("speed_0", speed, 0);

        // Bouncing dir button, then a clean 10-cycle hold.
        n = tog_cnt;
        repeat (2) begin
            p_btn[0] = 1'b1;
            idle(2);
            p_btn[0] = 1'b0;
            idle(2);
        end
        p_btn[0] = 1'b1;
        tick();
        t = cyc;
        idle(9);
        p_btn[0] = 1'b0;
        idle(20);
        chk("dir_pulse_count", tog_cnt - n, 1);
        chk("dir_pulse_cycle", last_tog - t, 6);

        // Dir press landing on a step cycle.
        n = both_cnt;
        k = 0;
        per = BASE >> m_speed;
        while (!(!m_paused && (m_phase + 6) % per == per - 1) && k < 600) begin
            tick();
            k++;
        end
        chk("align_dir_budget", int'(k < 600), 1);
        press(0, N + 2, 1'b0);
        chk("dir_with_step", both_cnt - n, 1);

        // Pause at count 100, hold 1000 cycles, resume.
        do_reset(3);
        k = 0;
        while (!(!m_init && m_phase == 94) && k < 600) begin
            tick();
            k++;
        end
        chk("align_pause_budget", int'(k < 600), 1);
        p_btn[3] = 1'b1;
        idle(N + 2);
        p_btn[3] = 1'b0;
        n = step_cnt;
        idle(1000);
        chk("paused_flag", paused, 1);
        chk("paused_no_steps", step_cnt - n, 0);
        press(3, N + 2, 1'b0);
        idle(200);
        chk("paused_cleared", paused, 0);
        chk("resume_gap", last_step - pause_cyc, 155);

        // Random button activity with glitches and overlaps.
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 4);
            if (k == 4) begin
                p_btn[1] = 1'b1;
                p_btn[2] = 1'b1;
                idle($urandom_range(N, N + 5));
                p_btn = 4'b0;
                idle(N + 4);
            end else begin
                press(k, $urandom_range(N, N + 8), 1'($urandom_range(0, 1)));
            end
            idle($urandom_range(0, 300));
        end

        // Reset while paused at speed 5 with a press mid-debounce.
        do_reset(3);
        idle(5);
        for (int i = 0; i < 5; i++) press(1, N + 1, 1'b0);
        press(3, N + 1, 1'b0);
        chk("pre_reset_speed", speed, 5);
        chk("pre_reset_paused", paused, 1);
        p_btn[1] = 1'b1;
        idle(2);
        p_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("in_reset_outputs",
                int'({step_en, toggle_dir, sr_reset, speed, paused}), 0);
        end
        p_btn = 4'b0;
        p_reset = 1'b0;
        tick();
        chk("post_reset_sr", sr_reset, 1);
        n = cyc;
        idle(300);
        chk("post_reset_sr_once", sr_cyc, n);
        chk("post_reset_speed", speed, 0);
        chk("post_reset_paused", paused, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/running_light_ctrl.md
# running_light_ctrl

Sequencer for the one-hot running-light shift register. It turns four raw push-buttons into the register's control strobes. Direction, speed and pause buttons are synchronised and debounced, and their press edges drive a speed/pause state machine. A programmable prescaler then produces the shift step enable. The block sits between the board buttons and the shift register: `step_en` gates the register's shift, and `toggle_dir` and `sr_reset` drive its control inputs.

## Interface
- `DEBOUNCE_CYCLES`, 50000, consecutive stable samples required before a debounced level changes (≥2).
- `BASE_DIV`, 1000000, step period in clk cycles at speed level 0 (≥256).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `btn_dir`  in  1  raw direction button, asynchronous, active-high.
- `btn_faster`  in  1  raw speed-up button, asynchronous, active-high.
- `btn_slower`  in  1  raw slow-down button, asynchronous, active-high.
- `btn_pause`  in  1  raw pause/run button, asynchronous, active-high.
- `step_en`  out  1  one-cycle pulse: shift register advances one position.
- `toggle_dir`  out  1  one-cycle pulse: shift register flips direction.
- `sr_reset`  out  1  one-cycle pulse: shift register reloads its start pattern.
- `speed`  out  3  current speed level, 0 slowest, 7 fastest.
- `paused`  out  1  high while in PAUSE.

## Operation
- Button path (per button):
  - 2-FF synchroniser, then debounce counter.
  - The counter increments while the synchronised sample differs from the debounced level, and clears when they agree.
  - On reaching `DEBOUNCE_CYCLES`-1 with a differing sample, the debounced level flips and the counter clears.
  - Press pulse = debounced rising edge, exactly 1 cycle. Releases generate nothing.
- FSM states: INIT, RUN, PAUSE.
  - INIT: `sr_reset`=1 for exactly one cycle, then unconditionally RUN.
  - RUN: a pause press goes to PAUSE.
  - PAUSE: a pause press goes to RUN.
- Speed:
  - A faster press increments `speed`, saturating at 7.
  - A slower press decrements `speed`, saturating at 0.
  - Both pressed in the same cycle: no change.
  - Speed presses are accepted in RUN and PAUSE.
- Prescaler:
  - period = `BASE_DIV` >> `speed`; counter width clog2(`BASE_DIV`).
  - In RUN the counter counts 0..period-1. `step_en` pulses in the cycle the count equals period-1, and the counter wraps to 0.
  - In PAUSE the counter holds and `step_en`=0.
  - Any accepted speed change clears the counter to 0 in the next cycle. A pending step is discarded.
- Direction: a dir press drives `toggle_dir`=1 in the same cycle as the press pulse, in any state except INIT.
  - A dir press during INIT is dropped.
  - `toggle_dir` and `step_en` may coincide; the register handles both in that cycle.
- Reset:
  - Clears synchronisers, debounce counters and debounced levels (0), prescaler (0) and `speed` (0).
  - Enters INIT.
  - Reset mid-operation (mid-debounce, mid-period, paused) fully restarts. No pulse is emitted while reset is high.

## Timing
- Output values during reset: `step_en`=0, `toggle_dir`=0, `sr_reset`=0, `speed`=0, `paused`=0.
- `sr_reset` asserts in the first cycle after reset deasserts.
- Press latency: the raw input held high from cycle t gives a press pulse at cycle t+2+`DEBOUNCE_CYCLES`.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no pulse.
- `paused` and `speed` are registered and update one cycle after the press pulse.
- First `step_en` after INIT: period cycles after entering RUN, i.e. `BASE_DIV` cycles at speed 0.
- Steady-state step spacing is exactly period cycles, with no drift.

## Structure
- Shared package `running_light_pkg`:
  - FSM state enum (INIT/RUN/PAUSE)
  - `SPEED_W`=3, `SPEED_MAX`=7
- Sub-module `btn_debounce` (synchroniser + debounce + press pulse), instantiated four times.
- Top level holds the FSM, speed register and prescaler.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `BASE_DIV`=256.
- Reset release: `sr_reset` pulses in exactly one cycle, then the first `step_en` arrives 256 cycles later, then every 256 cycles; `speed`=0.
- 3 faster presses: `speed`=3, step spacing 32. 10 faster presses: `speed`=7, spacing 2. Slower presses at 0: `speed` stays 0.
- `btn_dir` bouncing 1-0-1-0 with 2-cycle glitches, then held high 10 cycles: exactly one `toggle_dir` pulse, at cycle t+6 of the stable high.
- Pause press at count 100 of a 256 period: `paused`=1 and no `step_en` for 1000 cycles. A second pause press resumes, and the next `step_en` comes 155 cycles after resume.
- Faster and slower press pulses in the same cycle: `speed` unchanged and prescaler not cleared. Dir press coinciding with a step: `toggle_dir` and `step_en` both high in the same cycle.
- Reset asserted mid-debounce and while paused at `speed`=5: all outputs 0 during reset, and afterwards `speed`=0, `paused`=0 and `sr_reset` pulses once.
